// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: default clocking, receiver state encoding, helpers.
package uart_rx_pkg;

    localparam int unsigned DEF_CLK_FREQ = 96_000_000;
    localparam int unsigned DEF_BAUD     = 3_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_RECOVER
    } rx_state_e;

    // 2-of-3 vote used to filter a bit from three mid-bit samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Both stages reset to RESET_VAL so an idle line reads idle straight out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized input, mid-bit 3-sample majority vote,
// one-cycle ready / framing-error pulses, stop bit not waited out.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic       clk_96mhz,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rxd_data,
    output logic       rxd_data_ready,
    output logic       framing_error
);

    localparam int unsigned CPB = CLK_FREQ / BAUD;
    localparam int unsigned H   = CPB / 2;
    localparam int unsigned TW  = $clog2(CPB);

    localparam logic [TW-1:0] T_LAST = TW'(CPB - 1);
    localparam logic [TW-1:0] T_S0   = TW'(H - 1);
    localparam logic [TW-1:0] T_S1   = TW'(H);
    localparam logic [TW-1:0] T_DEC  = TW'(H + 1);

    if (CPB < 8) begin : g_bad_cpb
        $error("uart_rx: CLK_FREQ/BAUD must be at least 8");
    end

    logic rs;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i (clk_96mhz),
        .rst_i (reset),
        .d_i   (rxd),
        .q_o   (rs)
    );

    rx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          s0_q, s0_d;
    logic          s1_q, s1_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          ferr_q, ferr_d;

    logic maj;
    logic decide;

    assign maj    = maj3(s0_q, s1_q, rs);
    assign decide = (timer_q == T_DEC);

    // State and datapath registers.
    always_ff @(posedge clk_96mhz or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state, bit timing, sampling and output pulse generation.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;

        // Timer free-runs across START/DATA/STOP so every decision lands
        // exactly CPB cycles after the previous one.
        if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) begin
            timer_d = (timer_q == T_LAST) ? '0 : timer_q + TW'(1);
            if (timer_q == T_S0) s0_d = rs;
            if (timer_q == T_S1) s1_d = rs;
        end

        case (state_q)
            ST_IDLE: begin
                timer_d   = '0;
                bit_idx_d = '0;
                if (!rs) state_d = ST_START;
            end
            ST_START: begin
                if (decide) begin
                    if (maj) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (maj) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_RECOVER;
                    end
                end
            end
            ST_RECOVER: begin
                timer_d = '0;
                if (rs) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign rxd_data       = data_q;
    assign rxd_data_ready = ready_q;
    assign framing_error  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at the default 96 MHz / 3 Mbaud (CPB = 32).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rxd_data;
    logic       rxd_data_ready;
    logic       framing_error;

    uart_rx dut (
        .clk_96mhz      (clk),
        .reset          (reset),
        .rxd            (rxd),
        .rxd_data       (rxd_data),
        .rxd_data_ready (rxd_data_ready),
        .framing_error  (framing_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observed pulses, sampled on the falling edge.
    int         rdy_cyc[$];
    logic [7:0] rdy_dat[$];
    int         ferr_cnt = 0;
    int         both_hi = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (rxd_data_ready) begin
                rdy_cyc.push_back(cyc);
                rdy_dat.push_back(rxd_data);
            end
            if (framing_error) ferr_cnt++;
            if (rxd_data_ready && framing_error) both_hi++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // All drive tasks start and end 1 ns after a rising edge.
    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int fall_cyc;

    task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb);
        logic [9:0] bits;
        bits     = {stop, d, 1'b0};
        fall_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         cpb;
        int         exp_rdy;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    // rxd driven low at cycle N: rs low after edge N+2, START at N+3,
    // ready 306 cycles later -> observed at cycle N+309.
    localparam int LAT_FROM_FALL = 309;

    initial begin
        int rc0;
        int fc0;

        vecs[0] = '{8'h01, 1'b1, 32, 1, 0, 8'h01};
        vecs[1] = '{8'h55, 1'b1, 31, 1, 0, 8'h55};
        vecs[2] = '{8'h55, 1'b1, 33, 1, 0, 8'h55};
        vecs[3] = '{8'hA5, 1'b0, 32, 0, 1, 8'h55};
        vecs[4] = '{8'h5A, 1'b1, 32, 1, 0, 8'h5A};
        vecs[5] = '{8'h00, 1'b1, 32, 1, 0, 8'h00};
        vecs[6] = '{8'hFF, 1'b1, 32, 1, 0, 8'hFF};

        // Reset state.
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data",  int'(rxd_data), 8'h00);
        check("reset_ready", int'(rxd_data_ready), 0);
        check("reset_ferr",  int'(framing_error), 0);
        reset = 1'b0;
        idle(10);

        // 10-cycle low glitch on idle line: no pulses.
        rc0 = rdy_cyc.size();
        fc0 = ferr_cnt;
        rxd = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        idle(64);
        check("glitch_ready", rdy_cyc.size() - rc0, 0);
        check("glitch_ferr",  ferr_cnt - fc0, 0);

        // Table of single frames.
        for (int v = 0; v < 7; v++) begin
            rc0 = rdy_cyc.size();
            fc0 = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].cpb);
            idle(64);
            check($sformatf("v%0d_ready_cnt", v), rdy_cyc.size() - rc0, vecs[v].exp_rdy);
            check($sformatf("v%0d_ferr_cnt", v),  ferr_cnt - fc0, vecs[v].exp_ferr);
            check($sformatf("v%0d_data", v),      int'(rxd_data), int'(vecs[v].exp_data));
            if (vecs[v].exp_rdy == 1 && rdy_cyc.size() == rc0 + 1)
                check($sformatf("v%0d_latency", v), rdy_cyc[rc0] - fall_cyc, LAT_FROM_FALL);
        end

        // Back-to-back frames, no idle gap.
        rc0 = rdy_cyc.size();
        fc0 = ferr_cnt;
        send_frame(8'h02, 1'b1, 32);
        send_frame(8'h03, 1'b1, 32);
        idle(64);
        check("b2b_ready_cnt", rdy_cyc.size() - rc0, 2);
        check("b2b_ferr_cnt",  ferr_cnt - fc0, 0);
        if (rdy_cyc.size() == rc0 + 2) begin
            check("b2b_spacing", rdy_cyc[rc0 + 1] - rdy_cyc[rc0], 320);
            check("b2b_data0",   int'(rdy_dat[rc0]), 8'h02);
            check("b2b_data1",   int'(rdy_dat[rc0 + 1]), 8'h03);
        end

        // Reset asserted mid data bit 4 of 0xFF, then 0x3C.
        rc0 = rdy_cyc.size();
        fc0 = ferr_cnt;
        rxd = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (4 * 32 + 16) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_data",  int'(rxd_data), 8'h00);
        check("midrst_ready", int'(rxd_data_ready), 0);
        check("midrst_ferr",  int'(framing_error), 0);
        reset = 1'b0;
        idle(40);
        send_frame(8'h3C, 1'b1, 32);
        idle(64);
        check("midrst_ready_cnt", rdy_cyc.size() - rc0, 1);
        check("midrst_ferr_cnt",  ferr_cnt - fc0, 0);
        check("midrst_rx_data",   int'(rxd_data), 8'h3C);

        check("ready_ferr_overlap", both_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
